// File: rtl/ctrl_pipe_hazard.sv
// Control-side E/M/W pipeline registers for the RV32I pipeline, with hazard handling.
// Handles load-use stalls, branch/jump flushes and E-stage operand forwarding.
module ctrl_pipe_hazard #(
  parameter int         RADDR_W = 5,
  parameter logic [1:0] RS_LOAD = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               RegWriteD,
  input  logic [1:0]         ResultSrcD,
  input  logic               MemWriteD,
  input  logic               JumpD,
  input  logic               BranchD,
  input  logic               ALUSrcD,
  input  logic [2:0]         ALUControlD,
  input  logic [RADDR_W-1:0] Rs1D,
  input  logic [RADDR_W-1:0] Rs2D,
  input  logic [RADDR_W-1:0] RdD,
  input  logic               ZeroE,
  output logic               ALUSrcE,
  output logic [2:0]         ALUControlE,
  output logic               PCSrcE,
  output logic               MemWriteM,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [RADDR_W-1:0] RdW,
  output logic               StallF,
  output logic               StallD,
  output logic               FlushD,
  output logic               FlushE,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE
);

  logic               reg_write_e, mem_write_e, jump_e, branch_e;
  logic [1:0]         result_src_e;
  logic [RADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic               reg_write_m;
  logic [1:0]         result_src_m;
  logic [RADDR_W-1:0] rd_m;
  logic               lw_stall;

  // A flushed E stage becomes an all-zero bubble: no writes, no branch.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      reg_write_e  <= 1'b0;
      result_src_e <= 2'b00;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      ALUSrcE      <= 1'b0;
      ALUControlE  <= 3'b000;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
    end else begin
      reg_write_e  <= RegWriteD;
      result_src_e <= ResultSrcD;
      mem_write_e  <= MemWriteD;
      jump_e       <= JumpD;
      branch_e     <= BranchD;
      ALUSrcE      <= ALUSrcD;
      ALUControlE  <= ALUControlD;
      rs1_e        <= Rs1D;
      rs2_e        <= Rs2D;
      rd_e         <= RdD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      MemWriteM    <= 1'b0;
      rd_m         <= '0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 2'b00;
      RdW          <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      result_src_m <= result_src_e;
      MemWriteM    <= mem_write_e;
      rd_m         <= rd_e;
      RegWriteW    <= reg_write_m;
      ResultSrcW   <= result_src_m;
      RdW          <= rd_m;
    end
  end

  always_comb begin
    PCSrcE   = (branch_e & ZeroE) | jump_e;
    lw_stall = (result_src_e == RS_LOAD) && (rd_e != '0) &&
               ((rd_e == Rs1D) || (rd_e == Rs2D));
    StallF   = lw_stall;
    StallD   = lw_stall;
    FlushD   = PCSrcE;
    FlushE   = lw_stall | PCSrcE;
  end

  // M holds the youngest result, so it takes priority over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs1_e))
      ForwardAE = 2'b01;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs2_e))
      ForwardBE = 2'b01;
  end

endmodule
